parity_checker: RTL and testbench

//   Streaming even/odd parity checker: the receive-side counterpart of the 36-bit
//   XOR-reduce parity generator. Accepts data words with an attached parity bit and

---
 rtl/parity_pkg.sv | 30 +++
 rtl/xor_group_reduce.sv | 17 +
 rtl/parity_checker.sv | 162 ++++++++++++++++
 tb/tb_parity_checker.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared constants, default-build types and the parity-error helper for the parity checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the default geometry (36-bit data in 6-bit groups, 16-bit counters). Instances
// that override these use their own parameters; the package values are only defaults.
package parity_pkg;

   localparam int W     = 36;
   localparam int GROUP = 6;
   localparam int NG    = W / GROUP;
   localparam int CNT_W = 16;

   typedef logic [W-1:0]     data_t;
   typedef logic [CNT_W-1:0] cnt_t;

   typedef struct packed {
      data_t          d;
      logic           p;
      logic [NG-1:0]  g;
   } s1_t;

   // Error when data parity, received parity bit and the mode bit do not cancel out.
   // With odd=0 a good word has an even total count of ones over data+parity.
   function automatic logic check_err(input logic data_par, input logic par_bit,
                                      input logic odd);
      return data_par ^ par_bit ^ odd;
   endfunction

endpackage

// File: rtl/xor_group_reduce.sv
// XOR-reduce of one GROUP-bit slice of the data word (first level of the parity tree).
// Latency: combinational.
// Backpressure: n/a.
//
// Ports:
//   grp_i  in  GROUP  data bits of one group
//   par_o  out 1      XOR of all bits in grp_i
module xor_group_reduce #(
   parameter int GROUP = parity_pkg::GROUP
) (
   input  logic [GROUP-1:0] grp_i,
   output logic             par_o
);

   assign par_o = ^grp_i;

endmodule

// File: rtl/parity_checker.sv
// Streaming even/odd parity checker with per-word error flag and error statistics.
// Latency: 2 cycles input handshake to out_valid when unstalled; 1 word/cycle throughput.
// Backpressure: in_ready = s1 can advance, combinational from out_ready; no skid buffer.
//
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   in_valid/in_ready       input handshake; in_data (W) + in_parity
//   out_valid/out_ready     output handshake; out_data (W, unmodified) + out_err
//   word_count              output handshakes since reset, wraps
//   err_count               errored output handshakes, saturates at all-ones
//   err_sticky              set on first errored output handshake, cleared by reset
//   first_err_idx           word_count value at the first errored handshake
module parity_checker #(
   parameter int W     = parity_pkg::W,
   parameter int GROUP = parity_pkg::GROUP,
   parameter int CNT_W = parity_pkg::CNT_W,
   parameter bit ODD   = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   input  logic             in_parity,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   output logic             out_err,
   output logic [CNT_W-1:0] word_count,
   output logic [CNT_W-1:0] err_count,
   output logic             err_sticky,
   output logic [CNT_W-1:0] first_err_idx
);

   import parity_pkg::*;

   localparam int N_GRP = W / GROUP;

   generate
      if ((W % GROUP) != 0) begin : g_bad_cfg
         $error("parity_checker: W must be a multiple of GROUP");
      end
   endgenerate

   typedef struct packed {
      logic [W-1:0]     d;
      logic             p;
      logic [N_GRP-1:0] g;
   } stage1_t;

   // ---------------------------------------------------------------
   // Stage-1 group XORs, computed straight off the input bus
   // ---------------------------------------------------------------
   logic [N_GRP-1:0] grp_par;

   generate
      for (genvar gi = 0; gi < N_GRP; gi++) begin : g_grp
         xor_group_reduce #(.GROUP(GROUP)) u_xor (
            .grp_i (in_data[gi*GROUP +: GROUP]),
            .par_o (grp_par[gi])
         );
      end
   endgenerate

   // ---------------------------------------------------------------
   // State
   // ---------------------------------------------------------------
   logic             s1_vld_q, s1_vld_d;
   stage1_t          s1_q, s1_d;
   logic             s2_vld_q, s2_vld_d;
   logic [W-1:0]     s2_dat_q, s2_dat_d;
   logic             s2_err_q, s2_err_d;
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] first_idx_q, first_idx_d;

   logic s1_adv, s2_adv, out_hs;

   // An empty stage always accepts, so bubbles collapse as the pipe refills.
   assign s2_adv   = !s2_vld_q || out_ready;
   assign s1_adv   = !s1_vld_q || s2_adv;
   assign out_hs   = s2_vld_q && out_ready;
   assign in_ready = s1_adv;

   always_comb begin
      s1_vld_d    = s1_vld_q;
      s1_d        = s1_q;
      s2_vld_d    = s2_vld_q;
      s2_dat_d    = s2_dat_q;
      s2_err_d    = s2_err_q;
      word_cnt_d  = word_cnt_q;
      err_cnt_d   = err_cnt_q;
      sticky_d    = sticky_q;
      first_idx_d = first_idx_q;

      if (s1_adv) begin
         s1_vld_d = in_valid;
         if (in_valid) begin
            s1_d.d = in_data;
            s1_d.p = in_parity;
            s1_d.g = grp_par;
         end
      end

      // Payload only loads with a real word so out_data stays put across bubbles.
      if (s2_adv) begin
         s2_vld_d = s1_vld_q;
         if (s1_vld_q) begin
            s2_dat_d = s1_q.d;
            s2_err_d = check_err(^s1_q.g, s1_q.p, ODD);
         end
      end

      if (out_hs) begin
         word_cnt_d = word_cnt_q + CNT_W'(1);
         if (s2_err_q) begin
            if (err_cnt_q != '1) begin
               err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            // Index is the pre-increment count, captured once until reset.
            if (!sticky_q) begin
               sticky_d    = 1'b1;
               first_idx_d = word_cnt_q;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_vld_q    <= 1'b0;
         s1_q        <= '0;
         s2_vld_q    <= 1'b0;
         s2_dat_q    <= '0;
         s2_err_q    <= 1'b0;
         word_cnt_q  <= '0;
         err_cnt_q   <= '0;
         sticky_q    <= 1'b0;
         first_idx_q <= '0;
      end else begin
         s1_vld_q    <= s1_vld_d;
         s1_q        <= s1_d;
         s2_vld_q    <= s2_vld_d;
         s2_dat_q    <= s2_dat_d;
         s2_err_q    <= s2_err_d;
         word_cnt_q  <= word_cnt_d;
         err_cnt_q   <= err_cnt_d;
         sticky_q    <= sticky_d;
         first_idx_q <= first_idx_d;
      end
   end

   assign out_valid     = s2_vld_q;
   assign out_data      = s2_dat_q;
   assign out_err       = s2_err_q;
   assign word_count    = word_cnt_q;
   assign err_count     = err_cnt_q;
   assign err_sticky    = sticky_q;
   assign first_err_idx = first_idx_q;

endmodule

// File: tb/tb_parity_checker.sv
// Self-checking bench for parity_checker: default even build, an odd-parity build
// and a 4-bit-counter build share clock and reset.
// Inputs driven 1 ns after posedge; outputs and handshakes sampled on negedge.
`timescale 1ns/1ps
module tb_parity_checker;

   localparam int W = 36;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic reset;

   // default build (even parity, 16-bit counters)
   logic          in_valid, in_ready, in_parity, out_valid, out_ready, out_err, err_sticky;
   logic [W-1:0]  in_data, out_data;
   logic [15:0]   word_count, err_count, first_err_idx;

   // odd-parity build
   logic          o_in_valid, o_in_ready, o_in_parity, o_out_valid, o_out_ready, o_out_err, o_err_sticky;
   logic [W-1:0]  o_in_data, o_out_data;
   logic [15:0]   o_word_count, o_err_count, o_first_err_idx;

   // 4-bit counter build
   logic          c_in_valid, c_in_ready, c_in_parity, c_out_valid, c_out_ready, c_out_err, c_err_sticky;
   logic [W-1:0]  c_in_data, c_out_data;
   logic [3:0]    c_word_count, c_err_count, c_first_err_idx;

   parity_checker u_dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_parity(in_parity),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
      .word_count(word_count), .err_count(err_count), .err_sticky(err_sticky),
      .first_err_idx(first_err_idx)
   );

   parity_checker #(.ODD(1'b1)) u_dut_odd (
      .clock(clock), .reset(reset),
      .in_valid(o_in_valid), .in_ready(o_in_ready), .in_data(o_in_data), .in_parity(o_in_parity),
      .out_valid(o_out_valid), .out_ready(o_out_ready), .out_data(o_out_data), .out_err(o_out_err),
      .word_count(o_word_count), .err_count(o_err_count), .err_sticky(o_err_sticky),
      .first_err_idx(o_first_err_idx)
   );

   parity_checker #(.CNT_W(4)) u_dut_c4 (
      .clock(clock), .reset(reset),
      .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data), .in_parity(c_in_parity),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .out_err(c_out_err),
      .word_count(c_word_count), .err_count(c_err_count), .err_sticky(c_err_sticky),
      .first_err_idx(c_first_err_idx)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // ---------------------------------------------------------------
   // Scoreboard for the default build: every accepted input is queued with
   // its expected error flag and the cycle it was accepted.
   // ---------------------------------------------------------------
   typedef struct packed {
      logic [W-1:0] d;
      logic         e;
      logic [31:0]  cyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [31:0] cyc     = 0;
   bit          chk_lat = 1'b0;

   always @(negedge clock) begin
      cyc = cyc + 1;
      if (reset) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_out", 64'd1, 64'd0);
            end else begin
               mon_e = sb.pop_front();
               chk("out_data", 64'(out_data), 64'(mon_e.d));
               chk("out_err", 64'(out_err), 64'(mon_e.e));
               if (chk_lat) chk("latency", 64'(cyc - mon_e.cyc), 64'd2);
            end
         end
         if (in_valid && in_ready) sb.push_back('{d: in_data, e: ^in_data ^ in_parity, cyc: cyc});
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Present one word and hold it until the checker accepts it; leaves in_valid high.
   task automatic send(input logic [W-1:0] d, input logic p);
      bit done;
      done      = 1'b0;
      in_valid  = 1'b1;
      in_data   = d;
      in_parity = p;
      for (int i = 0; i < 64 && !done; i++) begin
         @(negedge clock);
         done = in_ready;
         @(posedge clock);
         #1;
      end
      if (!done) chk("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      in_valid = 1'b0;
      repeat (5) tick();
      chk("drained", 64'(sb.size()), 64'd0);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      reset    = 1'b1;
      tick();
      tick();
      reset    = 1'b0;
   endtask

   logic [W-1:0] wd;

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      in_valid   = 1'b0; in_data   = '0; in_parity   = 1'b0; out_ready   = 1'b1;
      o_in_valid = 1'b0; o_in_data = '0; o_in_parity = 1'b0; o_out_ready = 1'b1;
      c_in_valid = 1'b0; c_in_data = '0; c_in_parity = 1'b0; c_out_ready = 1'b1;
      tick();
      tick();

      // reset state
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_err", 64'(out_err), 64'd0);
      chk("rst_word_count", 64'(word_count), 64'd0);
      chk("rst_err_count", 64'(err_count), 64'd0);
      chk("rst_err_sticky", 64'(err_sticky), 64'd0);
      chk("rst_first_idx", 64'(first_err_idx), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      reset = 1'b0;

      // 50 good words back to back, consumer always ready
      chk_lat = 1'b1;
      for (int i = 0; i < 50; i++) begin
         wd = {4'(i), 32'(i) * 32'h9E37_79B9};
         send(wd, ^wd);
      end
      drain();
      chk("t1_word_count", 64'(word_count), 64'd50);
      chk("t1_err_count", 64'(err_count), 64'd0);
      chk("t1_err_sticky", 64'(err_sticky), 64'd0);

      // one bad word as word #3
      do_reset();
      send(36'h0_0000_00A5, 1'b0);   // four ones: even
      send(36'h8_0000_0001, 1'b0);   // two ones: even
      send(36'h0_0000_0007, 1'b1);   // three ones + parity
      send(36'h0_0000_0001, 1'b0);   // bad
      send(36'hF_0000_000F, 1'b0);
      send(36'h0_0001_0000, 1'b1);
      drain();
      chk("t2_word_count", 64'(word_count), 64'd6);
      chk("t2_err_count", 64'(err_count), 64'd1);
      chk("t2_err_sticky", 64'(err_sticky), 64'd1);
      chk("t2_first_idx", 64'(first_err_idx), 64'd3);
      send(36'h0_0000_0003, 1'b1);   // bad as word #6
      drain();
      chk("t2b_err_count", 64'(err_count), 64'd2);
      chk("t2b_first_idx", 64'(first_err_idx), 64'd3);
      chk("t2b_word_count", 64'(word_count), 64'd7);
      chk_lat = 1'b0;

      // consumer stalls for 5 cycles under continuous input
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 36'h1_1111_1111; in_parity = 1'b1;  // nine ones
      tick();
      in_data   = 36'h2_2222_2222; in_parity = 1'b1;
      tick();
      in_data   = 36'h3_3333_3333; in_parity = 1'b0;  // eighteen ones
      chk("t3_in_ready_fall", 64'(in_ready), 64'd0);
      chk("t3_out_valid", 64'(out_valid), 64'd1);
      chk("t3_out_data_hold", 64'(out_data), 64'h1_1111_1111);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t3_in_ready_low", 64'(in_ready), 64'd0);
         chk("t3_out_data_stable", 64'(out_data), 64'h1_1111_1111);
      end
      out_ready = 1'b1;
      send(36'h3_3333_3333, 1'b0);
      send(36'h4_4444_4444, 1'b1);
      send(36'h5_5555_5555, 1'b0);
      drain();
      chk("t3_word_count", 64'(word_count), 64'd12);

      // odd-parity build
      o_in_valid = 1'b1; o_in_data = 36'hF_FFFF_FFFF; o_in_parity = 1'b1;
      tick(); o_in_valid = 1'b0; tick();
      chk("odd_v1", 64'(o_out_valid), 64'd1);
      chk("odd_ff_p1_err", 64'(o_out_err), 64'd0);
      tick();
      o_in_valid = 1'b1; o_in_data = 36'hF_FFFF_FFFF; o_in_parity = 1'b0;
      tick(); o_in_valid = 1'b0; tick();
      chk("odd_v2", 64'(o_out_valid), 64'd1);
      chk("odd_ff_p0_err", 64'(o_out_err), 64'd1);
      tick();
      o_in_valid = 1'b1; o_in_data = 36'h0_0000_0001; o_in_parity = 1'b0;
      tick(); o_in_valid = 1'b0; tick();
      chk("odd_1_p0_err", 64'(o_out_err), 64'd0);
      tick();
      chk("odd_word_count", 64'(o_word_count), 64'd3);
      chk("odd_err_count", 64'(o_err_count), 64'd1);
      chk("odd_first_idx", 64'(o_first_err_idx), 64'd1);

      // 4-bit counters: 20 bad words
      c_in_valid = 1'b1; c_in_data = 36'h0_0000_0001; c_in_parity = 1'b0;
      repeat (20) tick();
      c_in_valid = 1'b0;
      repeat (4) tick();
      chk("c4_err_sat", 64'(c_err_count), 64'd15);
      chk("c4_word_wrap", 64'(c_word_count), 64'd4);
      chk("c4_first_idx", 64'(c_first_err_idx), 64'd0);
      chk("c4_sticky", 64'(c_err_sticky), 64'd1);

      // reset with two words in flight
      send(36'hA_AAAA_AAAA, 1'b0);
      send(36'h5_0000_0005, 1'b0);
      in_valid = 1'b0;
      reset    = 1'b1;
      chk("t6_inflight", 64'(out_valid), 64'd1);
      tick();
      chk("t6_out_valid", 64'(out_valid), 64'd0);
      chk("t6_word_count", 64'(word_count), 64'd0);
      chk("t6_err_count", 64'(err_count), 64'd0);
      chk("t6_err_sticky", 64'(err_sticky), 64'd0);
      chk("t6_first_idx", 64'(first_err_idx), 64'd0);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t6_no_ghost", 64'(out_valid), 64'd0);
      end
      chk("t6_word_count_after", 64'(word_count), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
